sad_row_feeder: RTL and testbench

//  Transmit side of the SAD row interface. On a start pulse, fetches the 8x8 current block and every

---
 rtl/sad_row_feeder.sv | 191 +++++++++++++++++++
 tb/tb_sad_row_feeder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sad_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sad_row_feeder
// Brief    : Fetches the current block and every search-window candidate from
//            frame memory and streams them row by row into the sad core.
// Revision : 1.0
// ============================================================================
module sad_row_feeder #(
    parameter int PIX_W   = 8,
    parameter int BLK     = 8,
    parameter int SR      = 4,
    parameter int COORD_W = 12,
    parameter int FRAME_W = 3840,
    parameter int FRAME_H = 2160,
    parameter int RD_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COORD_W-1:0]     blk_x,
    input  logic [COORD_W-1:0]     blk_y,
    output logic                   busy,
    output logic                   done,
    output logic                   crt_rd_en,
    output logic [COORD_W-1:0]     crt_rd_x,
    output logic [COORD_W-1:0]     crt_rd_y,
    input  logic [BLK*PIX_W-1:0]   crt_rd_data,
    output logic                   pre_rd_en,
    output logic [COORD_W-1:0]     pre_rd_x,
    output logic [COORD_W-1:0]     pre_rd_y,
    input  logic [BLK*PIX_W-1:0]   pre_rd_data,
    output logic                   row_valid,
    output logic [BLK*PIX_W-1:0]   pre_frame,
    output logic [BLK*PIX_W-1:0]   crt_frame,
    output logic                   crt_keep,
    output logic [2:0]             row_idx,
    output logic                   cand_last,
    output logic [COORD_W-1:0]     cand_dx,
    output logic [COORD_W-1:0]     cand_dy
);

    localparam int SUM_W = COORD_W + 2;
    localparam int SB_W  = 2*COORD_W + 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [COORD_W-1:0] c_NEG_SR   = COORD_W'(-SR);
    localparam logic [COORD_W-1:0] c_POS_SR   = COORD_W'(SR);
    localparam logic [2:0]         c_ROW_LAST = 3'(BLK-1);
    localparam logic signed [SUM_W-1:0] c_X_MAX = SUM_W'(FRAME_W-BLK);
    localparam logic signed [SUM_W-1:0] c_Y_MAX = SUM_W'(FRAME_H-1);

    logic [1:0]          r_state;
    logic [COORD_W-1:0]  r_blk_x, r_blk_y;
    logic [COORD_W-1:0]  r_dx, r_dy;
    logic [2:0]          r_row;
    logic                r_rd_en;
    logic                r_out_jlast;
    logic [SB_W-1:0]     r_pipe [RD_LAT];

    logic                w_cand0, w_last_row, w_job_last;
    logic signed [SUM_W-1:0] w_sum_x, w_sum_y;
    logic [SB_W-1:0]     w_sb, w_tap;

    assign w_cand0    = (r_dx == c_NEG_SR) && (r_dy == c_NEG_SR);
    assign w_last_row = (r_row == c_ROW_LAST);
    assign w_job_last = w_last_row && (r_dx == c_POS_SR) && (r_dy == c_POS_SR);

    assign pre_rd_en = r_rd_en;
    assign crt_rd_en = r_rd_en && w_cand0;
    assign crt_rd_x  = r_blk_x;
    assign crt_rd_y  = r_blk_y + COORD_W'(r_row);

    // Sign-extended sums so negative displacements near the origin clamp to 0.
    always_comb begin
        w_sum_x = $signed({2'b00, r_blk_x}) + $signed({{2{r_dx[COORD_W-1]}}, r_dx});
        w_sum_y = $signed({2'b00, r_blk_y}) + $signed({{2{r_dy[COORD_W-1]}}, r_dy})
                + $signed(SUM_W'(r_row));
        if (w_sum_x < 0)
            pre_rd_x = '0;
        else if (w_sum_x > c_X_MAX)
            pre_rd_x = c_X_MAX[COORD_W-1:0];
        else
            pre_rd_x = w_sum_x[COORD_W-1:0];
        if (w_sum_y < 0)
            pre_rd_y = '0;
        else if (w_sum_y > c_Y_MAX)
            pre_rd_y = c_Y_MAX[COORD_W-1:0];
        else
            pre_rd_y = w_sum_y[COORD_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_blk_x <= '0;
            r_blk_y <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_row   <= '0;
            r_rd_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_blk_x <= blk_x;
                        r_blk_y <= blk_y;
                        r_dx    <= c_NEG_SR;
                        r_dy    <= c_NEG_SR;
                        r_row   <= '0;
                        r_rd_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_job_last) begin
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                    end else if (w_last_row) begin
                        r_row <= '0;
                        if (r_dx == c_POS_SR) begin
                            r_dx <= c_NEG_SR;
                            r_dy <= r_dy + COORD_W'(1);
                        end else begin
                            r_dx <= r_dx + COORD_W'(1);
                        end
                    end else begin
                        r_row <= r_row + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (row_valid && r_out_jlast) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sideband travels alongside the memory read latency: valid, keep, job-last, row, dx, dy.
    assign w_sb  = {r_rd_en, ~w_cand0, w_job_last, r_row, r_dx, r_dy};
    assign w_tap = r_pipe[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++)
                r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_sb;
            for (int i = 1; i < RD_LAT; i++)
                r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_valid   <= 1'b0;
            done        <= 1'b0;
            pre_frame   <= '0;
            crt_frame   <= '0;
            crt_keep    <= 1'b0;
            row_idx     <= '0;
            cand_last   <= 1'b0;
            cand_dx     <= '0;
            cand_dy     <= '0;
            r_out_jlast <= 1'b0;
        end else begin
            row_valid <= w_tap[SB_W-1];
            done      <= (r_state == S_DRAIN) && row_valid && r_out_jlast;
            if (w_tap[SB_W-1]) begin
                pre_frame   <= pre_rd_data;
                crt_frame   <= w_tap[SB_W-2] ? '0 : crt_rd_data;
                crt_keep    <= w_tap[SB_W-2];
                r_out_jlast <= w_tap[SB_W-3];
                row_idx     <= w_tap[2*COORD_W+2:2*COORD_W];
                cand_last   <= (w_tap[2*COORD_W+2:2*COORD_W] == c_ROW_LAST);
                cand_dx     <= w_tap[2*COORD_W-1:COORD_W];
                cand_dy     <= w_tap[COORD_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_row_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_row_feeder
// Brief    : Randomized scoreboard bench for sad_row_feeder with a frame-memory model.
// Revision : 1.0
// ============================================================================
`timescale 1ps/1ps
module tb_sad_row_feeder;

    localparam int BLK = 8, SR = 4, CW = 12, FW = 3840, FH = 2160;
    localparam int ROWS = BLK*(2*SR+1)*(2*SR+1);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [CW-1:0] blk_x = '0, blk_y = '0;
    logic busy, done, crt_rd_en, pre_rd_en, row_valid, crt_keep, cand_last;
    logic [CW-1:0] crt_rd_x, crt_rd_y, pre_rd_x, pre_rd_y, cand_dx, cand_dy;
    logic [63:0] crt_rd_data = '0, pre_rd_data = '0, pre_d1 = '0, crt_d1 = '0;
    logic [63:0] pre_frame, crt_frame;
    logic [2:0] row_idx;

    sad_row_feeder dut (
        .clk(clk), .rst(rst), .start(start), .blk_x(blk_x), .blk_y(blk_y),
        .busy(busy), .done(done),
        .crt_rd_en(crt_rd_en), .crt_rd_x(crt_rd_x), .crt_rd_y(crt_rd_y), .crt_rd_data(crt_rd_data),
        .pre_rd_en(pre_rd_en), .pre_rd_x(pre_rd_x), .pre_rd_y(pre_rd_y), .pre_rd_data(pre_rd_data),
        .row_valid(row_valid), .pre_frame(pre_frame), .crt_frame(crt_frame), .crt_keep(crt_keep),
        .row_idx(row_idx), .cand_last(cand_last), .cand_dx(cand_dx), .cand_dy(cand_dy)
    );

    always #50 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] row_of(input logic [11:0] x, input logic [11:0] y);
        logic [71:0] t;
        t = {y, x, y, x, y, x};
        return t[63:0];
    endfunction

    // Frame memory: data appears two cycles after the read-enable cycle.
    always @(posedge clk) begin
        pre_d1      <= pre_rd_en ? row_of(pre_rd_x, pre_rd_y) : {$urandom, $urandom};
        crt_d1      <= crt_rd_en ? ~row_of(crt_rd_x, crt_rd_y) : {$urandom, $urandom};
        pre_rd_data <= pre_d1;
        crt_rd_data <= crt_d1;
    end

    int total = 0, bad = 0;
    logic [156:0] exp_q[$];
    int start0 = 0, n_rows = 0, n_rd = 0, n_crt = 0, n_done = 0, first_rel = -1, done_rel = -1;

    task automatic chk(input string nm, input logic [156:0] act, input logic [156:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic build_expected(input int bx, input int by);
        int idx = 0;
        exp_q.delete();
        for (int dy = -SR; dy <= SR; dy++)
            for (int dx = -SR; dx <= SR; dx++)
                for (int r = 0; r < BLK; r++) begin
                    int px = clampi(bx + dx, 0, FW - BLK);
                    int py = clampi(by + dy + r, 0, FH - 1);
                    logic [63:0] pre = row_of(12'(px), 12'(py));
                    logic [63:0] crt = (idx < BLK) ? ~row_of(12'(bx), 12'(by + r)) : 64'd0;
                    exp_q.push_back({pre, crt, idx >= BLK, 3'(r), r == BLK - 1, 12'(dx), 12'(dy)});
                    idx++;
                end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pre_rd_en) n_rd++;
            if (crt_rd_en) n_crt++;
            if (row_valid) begin
                n_rows++;
                if (n_rows == 1) first_rel = cyc - start0;
                if (exp_q.size() == 0)
                    chk("extra_row", 157'(row_idx), ~157'(row_idx));
                else
                    chk("row", {pre_frame, crt_frame, crt_keep, row_idx, cand_last, cand_dx, cand_dy},
                        exp_q.pop_front());
            end
            if (done) begin
                n_done++;
                done_rel = cyc - start0;
            end
        end
    end

    task automatic run_job(input int bx, input int by, input bit extra_start, input bit abort);
        bit got_done = 0;
        build_expected(bx, by);
        @(negedge clk);
        n_rows = 0; n_rd = 0; n_crt = 0; n_done = 0; first_rel = -1; done_rel = -1;
        start = 1'b1; blk_x = 12'(bx); blk_y = 12'(by); start0 = cyc;
        @(negedge clk);
        start = 1'b0; blk_x = 12'($urandom); blk_y = 12'($urandom);
        chk("busy_rise", {busy, pre_rd_en}, 2'b11);
        if (extra_start) begin
            while (cyc - start0 < 99) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort) begin
            while (cyc - start0 < 200) @(negedge clk);
            #10 rst = 1'b1;
            #1 chk("abort_zero", {row_valid, done, busy, pre_rd_en, crt_rd_en, crt_keep, row_idx,
                                  cand_dx, pre_frame, crt_frame}, '0);
            exp_q.delete();
            @(negedge clk);
            rst = 1'b0;
            repeat (4) @(negedge clk);
            #1 chk("abort_quiet", {row_valid, busy, n_done[0]}, '0);
            return;
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin got_done = 1; break; end
        end
        if (!got_done) begin
            chk("done_timeout", 1'b0, 1'b1);
            return;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("row_count", 157'(n_rows), 157'(ROWS));
        chk("first_row_cycle", 157'(first_rel), 157'(4));
        chk("done_cycle", 157'(done_rel), 157'(ROWS + 4));
        chk("rd_count", {32'(n_rd), 32'(n_crt), 32'(n_done)}, {32'(ROWS), 32'(BLK), 32'd1});
        chk("idle_after", {busy, row_valid, 32'(exp_q.size())}, '0);
    endtask

    initial begin
        #1 chk("reset_out", {busy, done, row_valid, crt_keep, pre_rd_en, crt_rd_en}, '0);
        #299 chk("reset_hold", {busy, done, row_valid, crt_keep, pre_rd_en, crt_rd_en, pre_frame}, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_job(64, 32, 1'b1, 1'b0);
        run_job(0, 0, 1'b0, 1'b0);
        run_job(3832, 2152, 1'b0, 1'b0);
        run_job(64, 32, 1'b0, 1'b1);
        run_job(100, 200, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            run_job(int'($urandom_range(0, FW - 1)), int'($urandom_range(0, FH - 1)), 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
